// File: rtl/wb_to_fta_burst_bridge.sv
// Wishbone slave to FTA master bridge: tagged requests, CSR-programmed
// bursts, bounded retries and a response timeout.
module wb_to_fta_burst_bridge #(
   parameter int          WID       = 256,
   parameter int          TIDW      = 4,
   parameter int          MAX_RTY   = 10,
   parameter int          TIMEOUT   = 1023,
   parameter int          POSTED_WR = 1,
   parameter logic [31:0] CSR_BASE  = 32'hBFFFFFF0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cs_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [WID/8-1:0]  sel_i,
   input  logic [31:0]       adr_i,
   input  logic [WID-1:0]    dat_i,
   output logic              ack_o,
   output logic [2:0]        err_o,
   output logic [WID-1:0]    dat_o,
   output logic              req_cyc,
   output logic              req_we,
   output logic [WID/8-1:0]  req_sel,
   output logic [31:0]       req_adr,
   output logic [WID-1:0]    req_dat,
   output logic [5:0]        req_blen,
   output logic [TIDW-1:0]   req_tid,
   input  logic              resp_stall,
   input  logic              resp_ack,
   input  logic              resp_rty,
   input  logic              resp_err,
   input  logic [TIDW-1:0]   resp_tid,
   input  logic [WID-1:0]    resp_dat
);

   localparam int TOW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           r_state;
   logic [5:0]       r_blen;
   logic [5:0]       r_rty_lim;
   logic [5:0]       r_rty_cnt;
   logic [31:0]      r_badr;
   logic [TIDW-1:0]  r_tid;
   logic [6:0]       r_beat;
   logic [6:0]       r_nbeat;
   logic [TOW-1:0]   r_to;

   logic             w_acc;
   logic             w_csr;
   logic             w_int;
   logic             w_match;
   logic [5:0]       w_rty_nxt;
   logic [6:0]       w_beat_nxt;
   logic [TOW-1:0]   w_to_nxt;
   logic [WID-1:0]   w_csr_rd;

   assign w_acc      = cyc_i & stb_i & cs_i;
   assign w_csr      = adr_i[31:4] == CSR_BASE[31:4];
   assign w_int      = w_csr & (adr_i[3:2] != 2'd2);
   assign w_match    = resp_tid == r_tid;
   assign w_rty_nxt  = r_rty_cnt + 6'd1;
   assign w_beat_nxt = r_beat + 7'd1;
   assign w_to_nxt   = r_to + 1'b1;

   always_comb begin
      w_csr_rd = '0;
      case (adr_i[3:2])
         2'd0:    w_csr_rd[5:0]  = r_blen;
         2'd1:    w_csr_rd[31:0] = r_badr;
         2'd3:    w_csr_rd[5:0]  = r_rty_lim;
         default: w_csr_rd       = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_blen    <= '0;
         r_rty_lim <= 6'(MAX_RTY);
         r_rty_cnt <= '0;
         r_badr    <= '0;
         r_tid     <= '0;
         r_beat    <= '0;
         r_nbeat   <= '0;
         r_to      <= '0;
         ack_o     <= 1'b0;
         err_o     <= '0;
         dat_o     <= '0;
         req_cyc   <= 1'b0;
         req_we    <= 1'b0;
         req_sel   <= '0;
         req_adr   <= '0;
         req_dat   <= '0;
         req_blen  <= '0;
         req_tid   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_acc && w_int) begin
                  if (we_i) begin
                     case (adr_i[3:2])
                        2'd0:    r_blen    <= dat_i[5:0];
                        2'd1:    r_badr    <= dat_i[31:0];
                        default: r_rty_lim <= dat_i[5:0];
                     endcase
                  end else begin
                     dat_o <= w_csr_rd;
                  end
                  err_o   <= '0;
                  ack_o   <= 1'b1;
                  r_state <= DONE;
               end else if (w_acc) begin
                  r_tid     <= r_tid + 1'b1;
                  req_tid   <= r_tid + 1'b1;
                  r_rty_cnt <= '0;
                  r_beat    <= '0;
                  r_to      <= '0;
                  req_cyc   <= 1'b1;
                  req_we    <= we_i;
                  req_dat   <= dat_i;
                  if (w_csr) begin
                     req_blen <= r_blen;
                     req_sel  <= '1;
                     req_adr  <= r_badr;
                     r_nbeat  <= {1'b0, r_blen} + 7'd1;
                  end else begin
                     req_blen <= '0;
                     req_sel  <= sel_i;
                     req_adr  <= adr_i;
                     r_nbeat  <= 7'd1;
                  end
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!cyc_i) begin
                  req_cyc <= 1'b0;
                  r_state <= IDLE;
               end else if (!resp_stall) begin
                  req_cyc <= 1'b0;
                  if (req_we && (POSTED_WR != 0)) begin
                     err_o   <= '0;
                     ack_o   <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // Responses tagged for an earlier transaction are dropped.
               if (!cyc_i) begin
                  r_state <= IDLE;
               end else if (w_match && resp_err) begin
                  err_o   <= 3'd1;
                  ack_o   <= 1'b1;
                  r_state <= DONE;
               end else if (w_match && resp_rty) begin
                  r_rty_cnt <= w_rty_nxt;
                  if (r_rty_lim != 6'd0 && w_rty_nxt == r_rty_lim) begin
                     err_o   <= 3'd1;
                     ack_o   <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_beat  <= '0;
                     dat_o   <= '0;
                     req_cyc <= 1'b1;
                     r_state <= ISSUE;
                  end
               end else if (w_match && resp_ack) begin
                  dat_o  <= resp_dat;
                  r_beat <= w_beat_nxt;
                  r_to   <= '0;
                  if (w_beat_nxt == r_nbeat) begin
                     err_o   <= '0;
                     ack_o   <= 1'b1;
                     r_state <= DONE;
                  end
               end else begin
                  r_to <= w_to_nxt;
                  if (w_to_nxt == TOW'(TIMEOUT)) begin
                     err_o   <= 3'd2;
                     ack_o   <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               if (!cyc_i) begin
                  ack_o   <= 1'b0;
                  dat_o   <= '0;
                  err_o   <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_to_fta_burst_bridge.sv
// Directed bench for wb_to_fta_burst_bridge: reads, CSR bursts, retries,
// stalled posted writes, timeout and asynchronous reset.
module tb_wb_to_fta_burst_bridge;

   localparam int WID  = 256;
   localparam int TIDW = 4;
   localparam logic [31:0] CSR = 32'hBFFFFFF0;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             cs_i, cyc_i, stb_i, we_i;
   logic [WID/8-1:0] sel_i;
   logic [31:0]      adr_i;
   logic [WID-1:0]   dat_i;
   logic             ack_o;
   logic [2:0]       err_o;
   logic [WID-1:0]   dat_o;
   logic             req_cyc, req_we;
   logic [WID/8-1:0] req_sel;
   logic [31:0]      req_adr;
   logic [WID-1:0]   req_dat;
   logic [5:0]       req_blen;
   logic [TIDW-1:0]  req_tid;
   logic             resp_stall, resp_ack, resp_rty, resp_err;
   logic [TIDW-1:0]  resp_tid;
   logic [WID-1:0]   resp_dat;

   int checks = 0;
   int failures = 0;

   wb_to_fta_burst_bridge #(
      .WID(WID), .TIDW(TIDW), .MAX_RTY(10), .TIMEOUT(15),
      .POSTED_WR(1), .CSR_BASE(CSR)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .cyc_i(cyc_i),
      .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i),
      .dat_i(dat_i), .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
      .req_cyc(req_cyc), .req_we(req_we), .req_sel(req_sel),
      .req_adr(req_adr), .req_dat(req_dat), .req_blen(req_blen),
      .req_tid(req_tid), .resp_stall(resp_stall), .resp_ack(resp_ack),
      .resp_rty(resp_rty), .resp_err(resp_err), .resp_tid(resp_tid),
      .resp_dat(resp_dat)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [WID-1:0] got,
                        input logic [WID-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic wb_start(input logic we, input logic [31:0] adr,
                           input logic [WID-1:0] dat);
      cyc_i = 1'b1; stb_i = 1'b1; cs_i = 1'b1;
      we_i = we; adr_i = adr; dat_i = dat;
   endtask

   task automatic wb_end;
      cyc_i = 1'b0; stb_i = 1'b0; cs_i = 1'b0; we_i = 1'b0;
      tick();
   endtask

   task automatic csr_wr(input logic [3:0] off, input logic [31:0] v);
      wb_start(1'b1, CSR | 32'(off), WID'(v));
      tick();
      check("csr_wr_ack", WID'(ack_o), 1);
      check("csr_wr_noreq", WID'(req_cyc), 0);
      wb_end();
   endtask

   task automatic resp_clear;
      resp_ack = 1'b0; resp_rty = 1'b0; resp_err = 1'b0;
   endtask

   logic [WID-1:0] pat;
   logic [31:0]    held_adr;

   initial begin
      rst_i = 1'b1;
      cs_i = 0; cyc_i = 0; stb_i = 0; we_i = 0;
      sel_i = '1; adr_i = '0; dat_i = '0;
      resp_stall = 0; resp_tid = '0; resp_dat = '0;
      resp_clear();
      tick(); tick();
      check("rst_ack", WID'(ack_o), 0);
      check("rst_req", WID'(req_cyc), 0);
      check("rst_err", WID'(err_o), 0);
      check("rst_tid", WID'(req_tid), 0);
      rst_i = 1'b0;
      tick();

      // single read
      for (int i = 0; i < WID/8; i++) pat[i*8 +: 8] = 8'hA5;
      wb_start(1'b0, 32'h1000, '0);
      tick();
      check("rd_req", WID'(req_cyc), 1);
      check("rd_tid", WID'(req_tid), 1);
      check("rd_adr", WID'(req_adr), 32'h1000);
      check("rd_blen", WID'(req_blen), 0);
      tick();
      check("rd_acc_drop", WID'(req_cyc), 0);
      check("rd_no_ack_yet", WID'(ack_o), 0);
      resp_ack = 1; resp_tid = 4'd1; resp_dat = pat;
      tick();
      resp_clear();
      check("rd_ack", WID'(ack_o), 1);
      check("rd_dat", dat_o, pat);
      check("rd_err", WID'(err_o), 0);
      tick();
      check("rd_ack_hold", WID'(ack_o), 1);
      wb_end();
      check("rd_ack_clr", WID'(ack_o), 0);
      check("rd_dat_clr", dat_o, 0);

      // CSR-programmed burst
      csr_wr(4'h0, 32'd3);
      csr_wr(4'h4, 32'h2000);
      wb_start(1'b0, CSR | 32'h8, '0);
      tick();
      check("bu_req", WID'(req_cyc), 1);
      check("bu_blen", WID'(req_blen), 3);
      check("bu_adr", WID'(req_adr), 32'h2000);
      check("bu_sel", WID'(req_sel), {(WID/8){1'b1}});
      check("bu_tid", WID'(req_tid), 2);
      tick();
      for (int i = 0; i < 4; i++) begin
         resp_ack = 1; resp_tid = 4'd2; resp_dat = WID'(8'h11 * (i + 1));
         tick();
         check("bu_ack", WID'(ack_o), (i == 3) ? 1 : 0);
      end
      resp_clear();
      check("bu_dat", dat_o, 8'h44);
      check("bu_err", WID'(err_o), 0);
      wb_end();

      // retry limit 2
      csr_wr(4'hC, 32'd2);
      wb_start(1'b0, 32'h3000, '0);
      tick();
      check("rt_req1", WID'(req_cyc), 1);
      check("rt_tid", WID'(req_tid), 3);
      tick();
      resp_rty = 1; resp_tid = 4'd3;
      tick();
      resp_clear();
      check("rt_req2", WID'(req_cyc), 1);
      check("rt_tid2", WID'(req_tid), 3);
      check("rt_noack", WID'(ack_o), 0);
      tick();
      resp_rty = 1; resp_tid = 4'd3;
      tick();
      resp_clear();
      check("rt_noreq3", WID'(req_cyc), 0);
      check("rt_ack", WID'(ack_o), 1);
      check("rt_err", WID'(err_o), 1);
      wb_end();

      // stalled posted write
      resp_stall = 1;
      sel_i = 32'h0000_00FF;
      wb_start(1'b1, 32'h4000, WID'(32'hDEAD_BEEF));
      tick();
      check("pw_req", WID'(req_cyc), 1);
      check("pw_we", WID'(req_we), 1);
      check("pw_sel", WID'(req_sel), 32'h0000_00FF);
      held_adr = req_adr;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pw_req_hold", WID'(req_cyc), 1);
         check("pw_adr_stable", WID'(req_adr), WID'(held_adr));
         check("pw_dat_stable", req_dat, WID'(32'hDEAD_BEEF));
         check("pw_noack", WID'(ack_o), 0);
      end
      resp_stall = 0;
      tick();
      check("pw_req_drop", WID'(req_cyc), 0);
      check("pw_ack", WID'(ack_o), 1);
      check("pw_err", WID'(err_o), 0);
      resp_ack = 1; resp_tid = 4'd4; resp_dat = pat;
      tick();
      resp_clear();
      check("pw_late_dat", dat_o, 0);
      check("pw_late_ack", WID'(ack_o), 1);
      sel_i = '1;
      wb_end();

      // timeout with a stale response injected
      wb_start(1'b0, 32'h5000, '0);
      tick();
      check("to_tid", WID'(req_tid), 5);
      tick();
      for (int i = 0; i < 14; i++) begin
         if (i == 4) begin
            resp_ack = 1; resp_tid = 4'd4; resp_dat = pat;
         end else begin
            resp_clear();
         end
         tick();
         check("to_wait", WID'(ack_o), 0);
      end
      resp_clear();
      tick();
      check("to_ack", WID'(ack_o), 1);
      check("to_err", WID'(err_o), 2);
      check("to_dat", dat_o, 0);
      wb_end();

      // asynchronous reset mid-WAIT
      wb_start(1'b0, 32'h6000, '0);
      tick(); tick(); tick();
      rst_i = 1'b1;
      #1;
      check("ar_req", WID'(req_cyc), 0);
      check("ar_ack", WID'(ack_o), 0);
      check("ar_err", WID'(err_o), 0);
      cyc_i = 0; stb_i = 0; cs_i = 0;
      tick();
      rst_i = 1'b0;
      tick();
      wb_start(1'b0, CSR | 32'hC, '0);
      tick();
      check("ar_csrc_ack", WID'(ack_o), 1);
      check("ar_csrc", dat_o, 10);
      wb_end();
      wb_start(1'b0, 32'h7000, '0);
      tick();
      check("ar_tid", WID'(req_tid), 1);
      wb_end();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/wb_to_fta_burst_bridge.md
# wb_to_fta_burst_bridge

Parametrised Wishbone-slave to FTA-master bridge with tagged transactions, programmable bursts, a programmable retry limit and a response timeout. It sits between a Wishbone-mastered peripheral or CPU port and the FTA bus fabric. It converts one Wishbone cycle into one FTA request, or into one burst request, and returns the completion status on `err_o`.

## Interface
- `WID`, 256: data width; sel width is `WID/8`.
- `TIDW`, 4: transaction-ID width.
- `MAX_RTY`, 10: reset value of the retry-limit register; 0 means unlimited retries.
- `TIMEOUT`, 1023: maximum WAIT cycles before a timeout error is reported.
- `POSTED_WR`, 1: 1 = Wishbone writes are acked as soon as the FTA request is accepted.
- `CSR_BASE`, 32'hBFFFFFF0: base of the 16-byte control window.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cs_i`, `cyc_i`, `stb_i`, `we_i` in 1: Wishbone slave controls.
- `sel_i` in WID/8: byte selects.
- `adr_i` in 32: byte address.
- `dat_i` in WID: write data.
- `ack_o` out 1: Wishbone acknowledge.
- `err_o` out 3: completion status. 0 = OKAY, 1 = ERR (slave error or retries exhausted), 2 = TIMEOUT.
- `dat_o` out WID: read data.
- `req_cyc`, `req_we` out 1: FTA request valid and write flag.
- `req_sel` out WID/8, `req_adr` out 32, `req_dat` out WID, `req_blen` out 6, `req_tid` out TIDW: FTA request fields.
- `resp_stall`, `resp_ack`, `resp_rty`, `resp_err` in 1: FTA response strobes.
- `resp_tid` in TIDW: tag of the incoming response.
- `resp_dat` in WID: response data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- A new Wishbone access is `cyc_i & stb_i & cs_i`, sampled in IDLE.
- CSR window (`adr_i[31:4]==CSR_BASE[31:4]`) decode on `adr_i[3:2]`:
  - offset 0: `blen` [5:0].
  - offset 4: burst address `badr`.
  - offset 8: burst trigger.
  - offset C: retry limit `rty_lim` [5:0].
- Accesses to offsets 0, 4 and C are handled internally.
  - Write: updates the register.
  - Read: returns the register zero-extended on `dat_o`.
  - Both go IDLE→DONE with no FTA traffic and `err_o=0`.
- Trigger (offset 8) and all non-CSR addresses go IDLE→ISSUE.
  - Both load `tid <= tid+1` and clear `rty_cnt`, the beat counter and the timeout counter.
  - Trigger request fields: `req_blen=blen`, `req_sel` all ones, `req_adr=badr`, expected beats `blen+1`.
  - Normal request fields: `req_blen=0`, `req_sel=sel_i`, `req_adr=adr_i`, expected beats 1.
  - Both: `req_we=we_i`, `req_dat=dat_i`, `req_tid=tid`.
- ISSUE: `req_cyc` is held high with stable fields until a cycle with `!resp_stall`; that cycle is the acceptance.
  - If `we_i & POSTED_WR`: go to DONE.
  - Otherwise: go to WAIT.
- WAIT ignores any response whose `resp_tid != tid`. For a matching response, priority is err > rty > ack:
  - `resp_err`: DONE with `err_o=1`.
  - `resp_rty`: `rty_cnt+1`.
    - If `rty_lim!=0` and `rty_cnt+1==rty_lim`: DONE with `err_o=1`.
    - Otherwise: back to ISSUE with the same tid and fields. The beat counter and data are cleared.
  - `resp_ack`: capture `resp_dat` into `dat_o` and increment the beat counter. On the last expected beat: DONE with `err_o=0`.
- Timeout counter: increments every WAIT cycle and clears on each matching ack. When it reaches `TIMEOUT`: DONE with `err_o=2`.
- DONE: `ack_o=1`, `dat_o` and `err_o` held. Leave on `!cyc_i` to IDLE, which clears `ack_o`, `dat_o` and `err_o`.
- `!cyc_i` in ISSUE or WAIT aborts to IDLE and drops `req_cyc`. Late responses carry the old tid and are ignored.
- Reset: state IDLE, every output 0, `tid=0`, `blen=0`, `badr=0`, `rty_lim=MAX_RTY`, all counters 0.

## Timing
- All outputs are registered.
- Access sampled at edge N:
  - `req_cyc` is high from N+1.
  - A CSR access has `ack_o` at N+1.
- FTA acceptance at edge A: the posted-write `ack_o` is at A+1.
- Final matching ack at edge M: `ack_o` and `dat_o` are valid at M+1.
- Minimum read latency is 3 cycles (N → req N+1 → ack N+2 → `ack_o` N+3).
- Retry reissue: `req_cyc` is high the cycle after `resp_rty`.
- `ack_o` never rises in the same cycle as `req_cyc`.
- `ack_o` stays high until the cycle after `cyc_i` falls.
- Asynchronous reset clears outputs immediately, mid-transaction included.

## Test plan
- Single read at 0x1000 (`sel_i`=all ones), slave acks 1 cycle after acceptance with 0xA5 pattern and matching tid -> `req_tid`=1, `ack_o` 3 cycles after `stb_i`, `dat_o`=pattern, `err_o`=0.
- Write CSR0=3 and CSR4=0x2000, then read CSR8; slave returns 4 acks 0x11, 0x22, 0x33, 0x44 -> `req_blen`=3, `req_adr`=0x2000, `req_sel` all ones, `ack_o` after the 4th ack, `dat_o`=0x44.
- Write CSRC=2, then read with `rty` answered twice -> exactly 2 requests issued, `ack_o` with `err_o`=1.
- `POSTED_WR`=1, write with `resp_stall` high for 3 cycles -> `req_cyc` held for 4 cycles with stable fields, `ack_o` the cycle after acceptance, later response ignored.
- Read with no response, `TIMEOUT`=15 -> `ack_o` with `err_o`=2 after 15 WAIT cycles; a response with a stale tid inserted during WAIT is ignored.
- Assert `rst_i` mid-WAIT -> `req_cyc`, `ack_o` and `err_o` go to 0 immediately; next access uses `req_tid`=1 and CSRC reads back 10.
